regx_bank: RTL and testbench



---
 rtl/regx_bank.sv | 170 +++++++++++++++++
 tb/tb_regx_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regx_bank.sv
// regx_bank: xdata byte register bank with optional atomic pair commit, debounced status inputs,
// sticky event latches and interrupt. Define XREGB_IRQ_EN to implement the IE register and irq flop.
module regx_bank #(
    parameter int unsigned         NREG      = 8,
    parameter logic [NREG/2-1:0]   PAIR_MASK = '0,
    parameter logic [8*NREG-1:0]   RST_VAL   = '0,
    parameter int unsigned         NSTS      = 8,
    parameter int unsigned         DBNC      = 3,
    parameter logic [NSTS-1:0]     EDGE_BOTH = '0,
    parameter int unsigned         STS_BASE  = 'h10,
    parameter logic [7:0]          UNREG_D   = 8'hff
) (
    input  logic                   clk,
    input  logic                   rrstz,
    input  logic                   regx_r,
    input  logic                   regx_w,
    input  logic [6:0]             regx_addr,
    input  logic [7:0]             regx_wdat,
    output logic [7:0]             regx_rdat,
    output logic [8*NREG-1:0]      r_reg,
    output logic [NREG-1:0]        we_reg,
    input  logic [NSTS-1:0]        di_sts,
    output logic [NSTS-1:0]        r_sts,
    output logic                   irq
);
    localparam int unsigned AW    = 7;
    localparam int unsigned CW    = 4;
    localparam int unsigned NPAIR = NREG / 2;
    localparam logic [AW-1:0] A_STS   = AW'(STS_BASE);
    localparam logic [AW-1:0] A_EVT   = AW'(STS_BASE + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(DBNC - 1);

    logic [AW-1:0]              d_addr;
    logic [NPAIR-1:0][7:0]      tmp_q;
    logic [NPAIR-1:0][7:0]      tmp_d;
    logic [8*NREG-1:0]          reg_d;
    logic [NREG-1:0]            we_d;
    logic [NSTS-1:0]            sync1;
    logic [NSTS-1:0]            sync2;
    logic [NSTS-1:0]            sts_d;
    logic [NSTS-1:0]            evt_q;
    logic [NSTS-1:0]            evt_d;
    logic [NSTS-1:0]            evt_set;
    logic [NSTS-1:0]            evt_clr;
    logic [NSTS-1:0][CW-1:0]    cnt_q;
    logic [NSTS-1:0][CW-1:0]    cnt_d;

    // Write decode: low half of a pair only loads tmp, high half commits both bytes together
    always_comb begin
        reg_d = r_reg;
        tmp_d = tmp_q;
        we_d  = '0;
        for (int unsigned p = 0; p < NPAIR; p++) begin
            if (regx_w && (regx_addr == AW'(2 * p))) begin
                if (PAIR_MASK[p]) begin
                    tmp_d[p] = regx_wdat;
                end else begin
                    reg_d[16*p +: 8] = regx_wdat;
                    we_d[2*p]        = 1'b1;
                end
            end
            if (regx_w && (regx_addr == AW'(2 * p + 1))) begin
                reg_d[16*p+8 +: 8] = regx_wdat;
                we_d[2*p+1]        = 1'b1;
                if (PAIR_MASK[p]) begin
                    reg_d[16*p +: 8] = tmp_q[p];
                    we_d[2*p]        = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rrstz) begin
        if (!rrstz) begin
            r_reg  <= RST_VAL;
            tmp_q  <= '0;
            we_reg <= '0;
            d_addr <= '0;
        end else begin
            r_reg  <= reg_d;
            tmp_q  <= tmp_d;
            we_reg <= we_d;
            if (regx_r) begin
                d_addr <= regx_addr;
            end
        end
    end

    // Debounce: count cycles the synchronised input disagrees with r_sts, toggle at DBNC
    always_comb begin
        sts_d = r_sts;
        cnt_d = '0;
        for (int unsigned i = 0; i < NSTS; i++) begin
            if (sync2[i] != r_sts[i]) begin
                if (cnt_q[i] == CNT_TOP) begin
                    sts_d[i] = ~r_sts[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Event latch: set has priority over a same-cycle write-1-to-clear
    always_comb begin
        evt_set = (sts_d & ~r_sts) | (~sts_d & r_sts & EDGE_BOTH);
        evt_clr = '0;
        if (regx_w && (regx_addr == A_EVT)) begin
            evt_clr = regx_wdat[NSTS-1:0];
        end
        evt_d = (evt_q & ~evt_clr) | evt_set;
    end

    always_ff @(posedge clk or negedge rrstz) begin
        if (!rrstz) begin
            sync1 <= '0;
            sync2 <= '0;
            r_sts <= '0;
            cnt_q <= '0;
            evt_q <= '0;
        end else begin
            sync1 <= di_sts;
            sync2 <= sync1;
            r_sts <= sts_d;
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

`ifdef XREGB_IRQ_EN
    localparam logic [AW-1:0] A_IE = AW'(STS_BASE + 2);
    logic [NSTS-1:0] ie_q;

    always_ff @(posedge clk or negedge rrstz) begin
        if (!rrstz) begin
            ie_q <= '0;
            irq  <= 1'b0;
        end else begin
            if (regx_w && (regx_addr == A_IE)) begin
                ie_q <= regx_wdat[NSTS-1:0];
            end
            irq <= |(evt_q & ie_q);
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read mux over the captured address and current contents
    always_comb begin
        regx_rdat = UNREG_D;
        for (int unsigned n = 0; n < NREG; n++) begin
            if (d_addr == AW'(n)) begin
                regx_rdat = r_reg[8*n +: 8];
            end
        end
        if (d_addr == A_STS) begin
            regx_rdat = 8'(r_sts);
        end
        if (d_addr == A_EVT) begin
            regx_rdat = 8'(evt_q);
        end
`ifdef XREGB_IRQ_EN
        if (d_addr == A_IE) begin
            regx_rdat = 8'(ie_q);
        end
`endif
    end

endmodule

// File: tb/tb_regx_bank.sv
// Directed self-checking bench for regx_bank: reset, plain/pair writes, reads, debounce, events, irq.
module tb_regx_bank;
    localparam int unsigned NREG = 8;
    localparam int unsigned NSTS = 8;
    localparam logic [63:0] RSTV = 64'h0102030405060708;
`ifdef XREGB_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rrstz = 1'b0;
    logic                regx_r = 1'b0;
    logic                regx_w = 1'b0;
    logic [6:0]          regx_addr = '0;
    logic [7:0]          regx_wdat = '0;
    logic [7:0]          regx_rdat;
    logic [8*NREG-1:0]   r_reg;
    logic [NREG-1:0]     we_reg;
    logic [NSTS-1:0]     di_sts = '0;
    logic [NSTS-1:0]     r_sts;
    logic                irq;

    int checks = 0;
    int failures = 0;

    regx_bank #(
        .NREG(NREG), .PAIR_MASK(4'b0001), .RST_VAL(RSTV), .NSTS(NSTS), .DBNC(3),
        .EDGE_BOTH(8'h02), .STS_BASE('h10), .UNREG_D(8'hff)
    ) dut (
        .clk(clk), .rrstz(rrstz), .regx_r(regx_r), .regx_w(regx_w), .regx_addr(regx_addr),
        .regx_wdat(regx_wdat), .regx_rdat(regx_rdat), .r_reg(r_reg), .we_reg(we_reg),
        .di_sts(di_sts), .r_sts(r_sts), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        regx_w = 1'b1; regx_addr = a; regx_wdat = d;
        tick();
        regx_w = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] a);
        regx_r = 1'b1; regx_addr = a;
        tick();
        regx_r = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (r_reg !== RSTV) begin failures++; $display("FAIL rst_r_reg got %h exp %h", r_reg, RSTV); end
        checks++; if (we_reg !== 8'h00) begin failures++; $display("FAIL rst_we got %h exp 00", we_reg); end
        checks++; if (regx_rdat !== 8'h08) begin failures++; $display("FAIL rst_rdat got %h exp 08", regx_rdat); end
        checks++; if (r_sts !== 8'h00) begin failures++; $display("FAIL rst_sts got %h exp 00", r_sts); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got %b exp 0", irq); end
        @(negedge clk);
        rrstz = 1'b1;
        tick();
        do_read(7'd5);
        checks++; if (regx_rdat !== 8'h03) begin failures++; $display("FAIL rd5 got %h exp 03", regx_rdat); end
        do_read(7'h40);
        checks++; if (regx_rdat !== 8'hff) begin failures++; $display("FAIL rd_unmapped got %h exp ff", regx_rdat); end
        do_read(7'h10);
        checks++; if (regx_rdat !== 8'h00) begin failures++; $display("FAIL rd_sts got %h exp 00", regx_rdat); end
    endtask

    task automatic test_plain();
        // write and read the same address on the same edge
        regx_w = 1'b1; regx_r = 1'b1; regx_addr = 7'd3; regx_wdat = 8'h3c;
        tick();
        regx_w = 1'b0; regx_r = 1'b0;
        checks++; if (we_reg !== 8'h08) begin failures++; $display("FAIL plain_we got %h exp 08", we_reg); end
        checks++; if (regx_rdat !== 8'h3c) begin failures++; $display("FAIL plain_rdw got %h exp 3c", regx_rdat); end
        tick();
        checks++; if (we_reg !== 8'h00) begin failures++; $display("FAIL plain_we_end got %h exp 00", we_reg); end
        do_write(7'd6, 8'h5a);
        checks++; if (r_reg !== 64'h015a03043c060708) begin failures++; $display("FAIL plain_r_reg got %h exp 015a03043c060708", r_reg); end
        do_read(7'h13);
        checks++; if (regx_rdat !== 8'hff) begin failures++; $display("FAIL rd_13 got %h exp ff", regx_rdat); end
    endtask

    task automatic test_pair();
        do_write(7'd0, 8'haa);
        checks++; if (we_reg !== 8'h00) begin failures++; $display("FAIL pair_lo_we got %h exp 00", we_reg); end
        checks++; if (r_reg[7:0] !== 8'h08) begin failures++; $display("FAIL pair_lo_reg got %h exp 08", r_reg[7:0]); end
        do_read(7'd0);
        checks++; if (regx_rdat !== 8'h08) begin failures++; $display("FAIL pair_lo_rd got %h exp 08", regx_rdat); end
        do_write(7'd1, 8'h55);
        checks++; if (r_reg[15:0] !== 16'h55aa) begin failures++; $display("FAIL pair_commit got %h exp 55aa", r_reg[15:0]); end
        checks++; if (we_reg !== 8'h03) begin failures++; $display("FAIL pair_we got %h exp 03", we_reg); end
        tick();
        checks++; if (we_reg !== 8'h00) begin failures++; $display("FAIL pair_we_end got %h exp 00", we_reg); end
        do_write(7'd0, 8'h11);
        do_write(7'd0, 8'h22);
        do_write(7'd1, 8'h33);
        checks++; if (r_reg[15:0] !== 16'h3322) begin failures++; $display("FAIL pair_last_wins got %h exp 3322", r_reg[15:0]); end
    endtask

    task automatic test_debounce();
        logic [7:0] exp_sts;
        di_sts[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_sts = (e >= 5 && e <= 8) ? 8'h01 : 8'h00;
            checks++; if (r_sts !== exp_sts) begin failures++; $display("FAIL dbnc_long edge %0d got %h exp %h", e, r_sts, exp_sts); end
            if (e == 4) di_sts[0] = 1'b0;
        end
        ticks(2);
        di_sts[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 2) di_sts[0] = 1'b0;
            checks++; if (r_sts !== 8'h00) begin failures++; $display("FAIL dbnc_glitch edge %0d got %h exp 00", e, r_sts); end
        end
    endtask

    task automatic test_events();
        logic       exp_irq;
        logic [7:0] exp_ie;
        exp_irq = IRQ_EN;
        exp_ie  = IRQ_EN ? 8'h01 : 8'hff;
        do_write(7'h11, 8'hff);
        do_write(7'h12, 8'h01);
        do_read(7'h12);
        checks++; if (regx_rdat !== exp_ie) begin failures++; $display("FAIL ie_rd got %h exp %h", regx_rdat, exp_ie); end
        do_read(7'h11);
        checks++; if (regx_rdat !== 8'h00) begin failures++; $display("FAIL evt_clr_rd got %h exp 00", regx_rdat); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle got %b exp 0", irq); end
        di_sts[0] = 1'b1;
        ticks(5);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got %b exp 0", irq); end
        tick();
        checks++; if (irq !== exp_irq) begin failures++; $display("FAIL irq_rise got %b exp %b", irq, exp_irq); end
        do_read(7'h11);
        checks++; if (regx_rdat !== 8'h01) begin failures++; $display("FAIL evt_rise got %h exp 01", regx_rdat); end
        do_write(7'h11, 8'h01);
        checks++; if (irq !== exp_irq) begin failures++; $display("FAIL irq_hold got %b exp %b", irq, exp_irq); end
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clr got %b exp 0", irq); end
        di_sts[0] = 1'b0;
        ticks(5);
        checks++; if (r_sts !== 8'h00) begin failures++; $display("FAIL sts_fall got %h exp 00", r_sts); end
        do_read(7'h11);
        checks++; if (regx_rdat !== 8'h00) begin failures++; $display("FAIL evt_nofall got %h exp 00", regx_rdat); end
        // bit 1 records both edges
        di_sts[1] = 1'b1;
        ticks(5);
        checks++; if (r_sts !== 8'h02) begin failures++; $display("FAIL sts_b1 got %h exp 02", r_sts); end
        do_write(7'h11, 8'h02);
        di_sts[1] = 1'b0;
        ticks(5);
        do_read(7'h11);
        checks++; if (regx_rdat !== 8'h02) begin failures++; $display("FAIL evt_fall_b1 got %h exp 02", regx_rdat); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_masked got %b exp 0", irq); end
        do_write(7'h12, 8'h03);
        tick();
        checks++; if (irq !== exp_irq) begin failures++; $display("FAIL irq_ie_set got %b exp %b", irq, exp_irq); end
        do_write(7'h12, 8'h00);
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_ie_clr got %b exp 0", irq); end
        do_write(7'h11, 8'hff);
    endtask

    task automatic test_collision();
        di_sts[0] = 1'b1;
        ticks(4);
        regx_w = 1'b1; regx_addr = 7'h11; regx_wdat = 8'h01;
        tick();
        regx_w = 1'b0;
        checks++; if (r_sts !== 8'h01) begin failures++; $display("FAIL coll_sts got %h exp 01", r_sts); end
        do_read(7'h11);
        checks++; if (regx_rdat !== 8'h01) begin failures++; $display("FAIL coll_evt got %h exp 01", regx_rdat); end
        di_sts[0] = 1'b0;
        ticks(6);
        do_write(7'h11, 8'hff);
    endtask

    task automatic test_reset_mid();
        do_write(7'd0, 8'h77);
        di_sts[2] = 1'b1;
        ticks(4);
        rrstz = 1'b0;
        #2;
        checks++; if (r_sts !== 8'h00) begin failures++; $display("FAIL mid_sts got %h exp 00", r_sts); end
        checks++; if (r_reg !== RSTV) begin failures++; $display("FAIL mid_r_reg got %h exp %h", r_reg, RSTV); end
        checks++; if (we_reg !== 8'h00) begin failures++; $display("FAIL mid_we got %h exp 00", we_reg); end
        checks++; if (regx_rdat !== 8'h08) begin failures++; $display("FAIL mid_rdat got %h exp 08", regx_rdat); end
        rrstz = 1'b1;
        ticks(4);
        checks++; if (r_sts !== 8'h00) begin failures++; $display("FAIL mid_early got %h exp 00", r_sts); end
        tick();
        checks++; if (r_sts !== 8'h04) begin failures++; $display("FAIL mid_full got %h exp 04", r_sts); end
        do_write(7'd1, 8'h99);
        checks++; if (r_reg[15:0] !== 16'h9900) begin failures++; $display("FAIL mid_tmp got %h exp 9900", r_reg[15:0]); end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_pair();
        test_debounce();
        test_events();
        test_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
